// File: rtl/ldl_ram_pkg.sv
// Shared types, constants and the byte-lane merge helper for the ldl single-port RAM family.
package ldl_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest supported word; callers pad their operands up to it and truncate the result.
    localparam int MAX_DW = 256;
    localparam int MAX_IW = 8;

    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0] oldWord,
        input logic [MAX_DW-1:0] newWord,
        input logic [MAX_DW-1:0] laneEn,
        input int                bew
    );
        logic [MAX_DW-1:0] result;
        result = oldWord;
        for (int i = 0; i < MAX_DW; i++) begin
            if (laneEn[MAX_IW'(i / bew)]) begin
                result[MAX_IW'(i)] = newWord[MAX_IW'(i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ldl_ram_clr_fsm.sv
// Clear engine: walks every word address once, driving the fill strobe and holding busy while it runs.
module ldl_ram_clr_fsm
    import ldl_ram_pkg::*;
#(
    parameter int DEPTH    = 10,
    parameter int AW       = $clog2(DEPTH),
    parameter int INIT_CLR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    output logic          busy_o,
    output logic          clrWe_o,
    output logic [AW-1:0] clrAddr_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_e    state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    // busy is tracked as its own register so it rises and falls on the same edges as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_CLR != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
            busy_q  <= (INIT_CLR != 0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign clrWe_o   = busy_q;
    assign clrAddr_o = cnt_q;

endmodule

// File: rtl/ldl_p1ram_v2.sv
// Single-port synchronous RAM with byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write result and a built-in clear engine.
module ldl_p1ram_v2
    import ldl_ram_pkg::*;
#(
    parameter int              DW       = 16,
    parameter int              BEW      = 8,
    parameter int              DEPTH    = 10,
    parameter int              AW       = $clog2(DEPTH),
    parameter int              RD_LAT   = 1,
    parameter int              RDW_MODE = 0,
    parameter int              INIT_CLR = 1,
    parameter logic [DW-1:0]   CLR_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    output logic                busy,
    input  logic                re,
    input  logic                we,
    input  logic [DW/BEW-1:0]   be,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       din,
    output logic [DW-1:0]       dout,
    output logic                rvalid
);

    localparam int NB = DW / BEW;

    if (DW % BEW != 0) begin : gChkLanes
        $error("ldl_p1ram_v2: DW must be a multiple of BEW");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : gChkLat
        $error("ldl_p1ram_v2: RD_LAT must be 1 or 2");
    end
    if (DEPTH < 2) begin : gChkDepth
        $error("ldl_p1ram_v2: DEPTH must be at least 2");
    end
    if (DW > MAX_DW) begin : gChkWidth
        $error("ldl_p1ram_v2: DW exceeds lane_merge capacity");
    end

    logic          clrWe;
    logic [AW-1:0] clrAddr;

    ldl_ram_clr_fsm #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .INIT_CLR (INIT_CLR)
    ) uClrFsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .busy_o    (busy),
        .clrWe_o   (clrWe),
        .clrAddr_o (clrAddr)
    );

    logic [DW-1:0] mem [DEPTH];

    // A clear request in the same cycle wins over the user access, which is dropped.
    logic          accEn;
    logic          rdAcc;
    logic          wrAcc;
    logic          addrOk;
    logic [DW-1:0] oldWord;
    logic [DW-1:0] mergedWord;
    logic [DW-1:0] rdData1_d;

    assign accEn      = !busy && !clr;
    assign rdAcc      = accEn && re;
    assign wrAcc      = accEn && we;
    assign addrOk     = 32'(addr) < DEPTH;
    assign oldWord    = addrOk ? mem[addr] : '0;
    assign mergedWord = DW'(lane_merge(MAX_DW'(oldWord), MAX_DW'(din), MAX_DW'(be), BEW));

    always_comb begin
        rdData1_d = '0;
        if (addrOk) begin
            rdData1_d = (RDW_MODE == RDW_NEW && wrAcc) ? mergedWord : oldWord;
        end
    end

    always_ff @(posedge clk) begin
        if (clrWe) begin
            mem[clrAddr] <= CLR_VAL;
        end else if (wrAcc && addrOk) begin
            mem[addr] <= mergedWord;
        end
    end

    logic [DW-1:0] rdData1_q;
    logic          rdValid1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData1_q  <= '0;
            rdValid1_q <= 1'b0;
        end else begin
            rdValid1_q <= rdAcc;
            if (rdAcc) begin
                rdData1_q <= rdData1_d;
            end
        end
    end

    if (RD_LAT == 2) begin : gLat2
        logic [DW-1:0] rdData2_q;
        logic          rdValid2_q;

        // Second stage only loads when a read completes, so dout holds between reads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdData2_q  <= '0;
                rdValid2_q <= 1'b0;
            end else begin
                rdValid2_q <= rdValid1_q;
                if (rdValid1_q) begin
                    rdData2_q <= rdData1_q;
                end
            end
        end

        assign dout   = rdData2_q;
        assign rvalid = rdValid2_q;
    end else begin : gLat1
        assign dout   = rdData1_q;
        assign rvalid = rdValid1_q;
    end

    logic unusedLanes;
    assign unusedLanes = (NB == 0);

endmodule

// File: tb/tb_ldl_p1ram_v2.sv
// Directed bench: three RAM instances (old-data/lat1, new-data/lat1, old-data/lat2) share one stimulus stream.
module tb_ldl_p1ram_v2;

    localparam logic [15:0] CLRV = 16'hA5A5;

    logic        clock;
    logic        rst_n;
    logic        clr;
    logic        re;
    logic        we;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] din;

    logic        busy0, busy1, busy2;
    logic [15:0] dout0, dout1, dout2;
    logic        rv0, rv1, rv2;

    int vecCount  = 0;
    int missCount = 0;

    ldl_p1ram_v2 #(.DW(16), .BEW(8), .DEPTH(10), .RD_LAT(1), .RDW_MODE(0),
                   .INIT_CLR(1), .CLR_VAL(CLRV)) dut0 (
        .clk(clock), .rst_n(rst_n), .clr(clr), .busy(busy0), .re(re), .we(we),
        .be(be), .addr(addr), .din(din), .dout(dout0), .rvalid(rv0));

    ldl_p1ram_v2 #(.DW(16), .BEW(8), .DEPTH(10), .RD_LAT(1), .RDW_MODE(1),
                   .INIT_CLR(1), .CLR_VAL(CLRV)) dut1 (
        .clk(clock), .rst_n(rst_n), .clr(clr), .busy(busy1), .re(re), .we(we),
        .be(be), .addr(addr), .din(din), .dout(dout1), .rvalid(rv1));

    ldl_p1ram_v2 #(.DW(16), .BEW(8), .DEPTH(10), .RD_LAT(2), .RDW_MODE(0),
                   .INIT_CLR(1), .CLR_VAL(CLRV)) dut2 (
        .clk(clock), .rst_n(rst_n), .clr(clr), .busy(busy2), .re(re), .we(we),
        .be(be), .addr(addr), .din(din), .dout(dout2), .rvalid(rv2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
    task automatic applyStimulus(input logic r, input logic w, input logic [1:0] b,
                                 input logic [3:0] a, input logic [15:0] d);
        re = r; we = w; be = b; addr = a; din = d;
        @(negedge clock);
        re = 1'b0; we = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic w, input logic [3:0] a, input logic [15:0] d,
                             input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        applyStimulus(1'b1, w, 2'b11, a, d);
        checkOutput({tag, ".rv0"}, 16'(rv0), 16'd1);
        checkOutput({tag, ".dout0"}, dout0, e0);
        checkOutput({tag, ".rv1"}, 16'(rv1), 16'd1);
        checkOutput({tag, ".dout1"}, dout1, e1);
        checkOutput({tag, ".rv2early"}, 16'(rv2), 16'd0);
        @(negedge clock);
        checkOutput({tag, ".rv2"}, 16'(rv2), 16'd1);
        checkOutput({tag, ".dout2"}, dout2, e2);
        checkOutput({tag, ".rv0late"}, 16'(rv0), 16'd0);
    endtask

    // Counts negedge samples with busy high, starting at the current negedge; bounded.
    task automatic countBusy(output int n, input logic checkIdle);
        n = 0;
        while (busy0 && n < 50) begin
            if (checkIdle) begin
                re = 1'b1; we = 1'b1; be = 2'b11; addr = 4'd2; din = 16'h1234;
                checkOutput("busy.rv0", 16'(rv0), 16'd0);
                checkOutput("busy.rv2", 16'(rv2), 16'd0);
            end
            n++;
            @(negedge clock);
        end
        re = 1'b0; we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; clr = 1'b0; re = 1'b0; we = 1'b0; be = 2'b00; addr = '0; din = '0;
        repeat (3) @(negedge clock);
        checkOutput("rst.dout0", dout0, 16'h0000);
        checkOutput("rst.rv0", 16'(rv0), 16'd0);
        checkOutput("rst.rv2", 16'(rv2), 16'd0);
        checkOutput("rst.busy0", 16'(busy0), 16'd1);
        checkOutput("rst.busy2", 16'(busy2), 16'd1);

        $display("[TB] test 1: initial clear");
        rst_n = 1'b1;
        countBusy(n, 1'b0);
        checkOutput("init.busyCycles", 16'(n), 16'd10);
        for (int i = 0; i < 10; i++) begin
            readCheck($sformatf("init.rd%0d", i), 1'b0, 4'(i), 16'h0, CLRV, CLRV, CLRV);
        end

        $display("[TB] test 2: byte-lane writes");
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd3, 16'h1234);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd3, 16'hFF00);
        readCheck("lane.rd3", 1'b0, 4'd3, 16'h0, 16'h1200, 16'h1200, 16'h1200);

        $display("[TB] test 3: read during write");
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd5, 16'h0001);
        readCheck("rdw.rw5", 1'b1, 4'd5, 16'h00FF, 16'h0001, 16'h00FF, 16'h0001);
        readCheck("rdw.rd5", 1'b0, 4'd5, 16'h0, 16'h00FF, 16'h00FF, 16'h00FF);

        $display("[TB] test 4: pipelined reads and out-of-range");
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd1, 16'h1111);
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd2, 16'h2222);
        re = 1'b1; addr = 4'd1;
        @(negedge clock);
        checkOutput("pipe.e1.rv0", 16'(rv0), 16'd1);
        checkOutput("pipe.e1.dout0", dout0, 16'h1111);
        checkOutput("pipe.e1.rv2", 16'(rv2), 16'd0);
        addr = 4'd2;
        @(negedge clock);
        checkOutput("pipe.e2.dout0", dout0, 16'h2222);
        checkOutput("pipe.e2.rv2", 16'(rv2), 16'd1);
        checkOutput("pipe.e2.dout2", dout2, 16'h1111);
        addr = 4'd3;
        @(negedge clock);
        checkOutput("pipe.e3.dout0", dout0, 16'h1200);
        checkOutput("pipe.e3.rv2", 16'(rv2), 16'd1);
        checkOutput("pipe.e3.dout2", dout2, 16'h2222);
        re = 1'b0;
        @(negedge clock);
        checkOutput("pipe.e4.rv0", 16'(rv0), 16'd0);
        checkOutput("pipe.e4.dout0hold", dout0, 16'h1200);
        checkOutput("pipe.e4.rv2", 16'(rv2), 16'd1);
        checkOutput("pipe.e4.dout2", dout2, 16'h1200);
        @(negedge clock);
        checkOutput("pipe.e5.rv2", 16'(rv2), 16'd0);
        checkOutput("pipe.e5.dout2hold", dout2, 16'h1200);
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd12, 16'hDEAD);
        readCheck("oob.rd12", 1'b0, 4'd12, 16'h0, 16'h0000, 16'h0000, 16'h0000);

        $display("[TB] test 5: clear request with colliding write");
        clr = 1'b1; re = 1'b1; we = 1'b1; be = 2'b11; addr = 4'd2; din = 16'hBEEF;
        @(negedge clock);
        clr = 1'b0; re = 1'b0; we = 1'b0;
        checkOutput("clr.rv0", 16'(rv0), 16'd0);
        countBusy(n, 1'b1);
        checkOutput("clr.busyCycles", 16'(n), 16'd10);
        @(negedge clock);
        checkOutput("clr.after.rv0", 16'(rv0), 16'd0);
        checkOutput("clr.after.rv2", 16'(rv2), 16'd0);
        readCheck("clr.rd2", 1'b0, 4'd2, 16'h0, CLRV, CLRV, CLRV);
        readCheck("clr.rd3", 1'b0, 4'd3, 16'h0, CLRV, CLRV, CLRV);

        $display("[TB] test 6: reset during clear");
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd7, 16'h7777);
        readCheck("rst6.rd7", 1'b0, 4'd7, 16'h0, 16'h7777, 16'h7777, 16'h7777);
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
        repeat (4) @(negedge clock);
        rst_n = 1'b0;
        #1;
        checkOutput("rst6.dout0", dout0, 16'h0000);
        checkOutput("rst6.dout2", dout2, 16'h0000);
        checkOutput("rst6.rv0", 16'(rv0), 16'd0);
        checkOutput("rst6.busy0", 16'(busy0), 16'd1);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        countBusy(n, 1'b0);
        checkOutput("rst6.busyCycles", 16'(n), 16'd10);
        for (int i = 0; i < 10; i++) begin
            readCheck($sformatf("rst6.rd%0d", i), 1'b0, 4'(i), 16'h0, CLRV, CLRV, CLRV);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/ldl_p1ram_v2.md
Name: ldl_p1ram_v2

Overview:
Second-generation single-port synchronous RAM: parametrised data width, depth and byte-lane width, with a selectable read latency (1 or 2) and a selectable read-during-write mode. A built-in clear engine fills the array with a constant after reset or on request, and signals this on busy. rvalid marks returned read data. Drop-in storage for FIFOs, tables and buffers.

Parameters:
DW, 16, data width in bits; must be a multiple of BEW
BEW, 8, byte-lane width; NB = DW/BEW lanes
DEPTH, 10, number of words; need not be a power of two
AW, $clog2(DEPTH), address width
RD_LAT, 1, read latency in cycles; legal values are 1 and 2
RDW_MODE, 0, same-cycle read/write result: 0 = old data, 1 = new (merged) data
INIT_CLR, 1, 1 = run the clear engine on reset release
CLR_VAL, '0, DW-bit value the clear engine writes

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  single-cycle request to re-clear the array
busy  out  1  clear engine active; accesses are ignored
re  in  1  read enable
we  in  1  write enable
be  in  NB  byte-lane write enables
addr  in  AW  word address
din  in  DW  write data
dout  out  DW  read data
rvalid  out  1  dout carries data for a read accepted RD_LAT cycles earlier

Behaviour:
- Reset (rst_n low): state = INIT_CLR ? CLEAR : IDLE; busy = INIT_CLR; clear counter = 0; dout = 0; rvalid = 0; read pipeline flushed. The array contents are not reset.
- FSM states:
  - IDLE: on an edge with clr=1, go to CLEAR with counter = 0. clr has priority over a re/we in the same cycle, which is dropped.
  - CLEAR: on every edge, write mem[cnt] = CLR_VAL and increment cnt. On the edge where cnt == DEPTH-1, go to IDLE.
  - clr while in CLEAR is ignored.
- busy is high exactly DEPTH cycles after reset release (INIT_CLR=1) or after the clr edge. The first access is accepted in the first cycle with busy low.
- An access is accepted when busy == 0.
- Write: each lane i with be[i] = 1 updates mem[addr][i*BEW +: BEW] at the edge. Lanes with be = 0 are unchanged.
- Read with RD_LAT=1: data is registered at the accept edge. dout is valid and rvalid = 1 in the next cycle.
- Read with RD_LAT=2: an extra output register stage is added. rvalid is high two cycles after re. Fully pipelined, so back-to-back reads give back-to-back rvalid.
- rvalid is high for one cycle per accepted read. dout holds its last value when no read completes.
- re and we together (same addr by construction):
  - RDW_MODE=0: dout = pre-write contents.
  - RDW_MODE=1: dout = old word with the be lanes replaced by din.
- addr >= DEPTH: the write is dropped. The read returns all-zero with rvalid still asserted.
- Reads already in the pipeline when clr is accepted complete normally.
- rst_n asserted mid-clear or mid-read: the pipeline is flushed, rvalid = 0, and the clear restarts from 0 after release (if INIT_CLR).
- Elaboration-time checks: DW % BEW == 0, RD_LAT in {1, 2}, DEPTH >= 2.

Decomposition:
- Package ldl_ram_pkg:
  - state enum (IDLE, CLEAR)
  - RDW_OLD/RDW_NEW constants
  - lane-merge function (old, new, be)
- Sub-module ldl_ram_clr_fsm: state, counter, busy, clear write address/strobe.
- The array, write mux (user vs. clear) and read pipeline stay in the top.

Test Plan:
1. DW=16, BEW=8, DEPTH=10, INIT_CLR=1, CLR_VAL=16'hA5A5. Release rst_n -> busy high exactly 10 cycles. Then reading addr 0..9 -> dout 16'hA5A5 each, rvalid one cycle after each re.
2. Write 16'h1234 be=2'b11 to addr 3, then 16'hFF00 be=2'b01 to addr 3. Read addr 3 -> 16'h12 in the high lane and 16'h00 in the low lane, i.e. dout = 16'h1200.
3. mem[5]=16'h0001, then re+we addr 5 with din 16'h00FF, be=2'b11 -> RDW_MODE=0: dout 16'h0001; RDW_MODE=1: dout 16'h00FF. A following read of addr 5 -> 16'h00FF in both modes.
4. RD_LAT=2: back-to-back re at addr 1,2,3 on cycles n..n+2 -> rvalid high on n+2..n+4 with data in order. Read of addr 12 -> dout 0, rvalid 1.
5. clr plus we(addr 2, 16'hBEEF) in the same cycle -> write dropped, busy high 10 cycles. re/we during busy are ignored with no rvalid. Addr 2 then reads CLR_VAL.
6. rst_n asserted in clear cycle 4 -> dout=0, rvalid=0 immediately. After release, busy high a full 10 cycles and all words read CLR_VAL.
